// File: rtl/sample_mul_arb_pkg.sv
// Shared types, default widths and the round-robin pick helper for sample_mul_arbiter.
package sample_mul_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_A_WIDTH    = 6;
  localparam int unsigned DEF_B_WIDTH    = 11;
  localparam int unsigned DEF_P_WIDTH    = 11;
  localparam int unsigned DEF_MUL_STAGES = 2;
  localparam int unsigned DEF_ID_WIDTH   = 2;

  // Full product width and clamp limits for the default geometry.
  localparam int unsigned FULL_W = DEF_A_WIDTH + DEF_B_WIDTH + 1;
  localparam int          P_MAX  = (1 << (DEF_P_WIDTH - 1)) - 1;
  localparam int          P_MIN  = -(1 << (DEF_P_WIDTH - 1));

  // Widest supported requester count; the pick helper works on this width.
  localparam int unsigned MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First valid requester at or after ptr, wrapping within num requesters.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int unsigned        num);
    rr_pick_t    r;
    int unsigned c;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      c = (32'(ptr) + k) % num;
      if (k < num && !r.found && valid[c[2:0]]) begin
        r.found = 1'b1;
        r.idx   = c[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_mul_arb_pipe.sv
// Shared multiply pipeline carrying {valid, id, product}; truncates the product
// to P_WIDTH bits at its output, or clamps it when SAMPLE_MUL_ARB_SAT_EN is defined.
module sample_mul_arb_pipe
  import sample_mul_arb_pkg::*;
#(
  parameter int unsigned A_WIDTH    = DEF_A_WIDTH,
  parameter int unsigned B_WIDTH    = DEF_B_WIDTH,
  parameter int unsigned P_WIDTH    = DEF_P_WIDTH,
  parameter int unsigned MUL_STAGES = DEF_MUL_STAGES,
  parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                in_valid,
  input  logic [ID_WIDTH-1:0] in_id,
  input  logic [A_WIDTH-1:0]  in_a,
  input  logic [B_WIDTH-1:0]  in_b,
  output logic                rsp_valid,
  output logic [ID_WIDTH-1:0] rsp_id,
  output logic [P_WIDTH-1:0]  rsp_p,
  output logic                busy
);

  localparam int unsigned PROD_W = A_WIDTH + B_WIDTH + 1;

  logic signed [A_WIDTH:0]   a_ext;
  logic signed [B_WIDTH-1:0] b_sgn;
  logic signed [PROD_W-1:0]  prod;

  assign a_ext = {1'b0, in_a};
  assign b_sgn = in_b;
  assign prod  = a_ext * b_sgn;

  logic                       pre_v;
  logic [ID_WIDTH-1:0]        pre_id;
  logic signed [PROD_W-1:0]   pre_p;
  logic                       mid_busy;

  generate
    if (MUL_STAGES == 1) begin : g_direct
      assign pre_v    = in_valid;
      assign pre_id   = in_id;
      assign pre_p    = prod;
      assign mid_busy = 1'b0;
    end else begin : g_regs
      localparam int unsigned D = MUL_STAGES - 1;
      logic [D-1:0]             sv;
      logic [ID_WIDTH-1:0]      sid [D];
      logic signed [PROD_W-1:0] sp  [D];

      // Valid shift chain; cleared on reset so in-flight entries are dropped.
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          sv <= '0;
        end else begin
          sv[0] <= in_valid;
          for (int unsigned k = 1; k < D; k++) begin
            sv[k] <= sv[k-1];
          end
        end
      end

      // Payload shift chain; only meaningful where the matching valid bit is set.
      always_ff @(posedge ap_clk) begin
        sid[0] <= in_id;
        sp[0]  <= prod;
        for (int unsigned k = 1; k < D; k++) begin
          sid[k] <= sid[k-1];
          sp[k]  <= sp[k-1];
        end
      end

      assign pre_v    = sv[D-1];
      assign pre_id   = sid[D-1];
      assign pre_p    = sp[D-1];
      assign mid_busy = |sv;
    end
  endgenerate

  logic [P_WIDTH-1:0] fmt_p;

`ifdef SAMPLE_MUL_ARB_SAT_EN
  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(PROD_W-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    {{(PROD_W-P_WIDTH+1){1'b1}}, {(P_WIDTH-1){1'b0}}};

  // Clamp the full product into the signed P_WIDTH range.
  always_comb begin
    if (pre_p > SAT_MAX) begin
      fmt_p = SAT_MAX[P_WIDTH-1:0];
    end else if (pre_p < SAT_MIN) begin
      fmt_p = SAT_MIN[P_WIDTH-1:0];
    end else begin
      fmt_p = pre_p[P_WIDTH-1:0];
    end
  end
`else
  logic unused_hi;

  // Wrap-around truncation: keep the low P_WIDTH bits.
  always_comb begin
    fmt_p     = pre_p[P_WIDTH-1:0];
    unused_hi = ^pre_p[PROD_W-1:P_WIDTH];
  end
`endif

  // Output stage; id/product hold their last values between results.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      rsp_valid <= pre_v;
      if (pre_v) begin
        rsp_id <= pre_id;
        rsp_p  <= fmt_p;
      end
    end
  end

  assign busy = rsp_valid | mid_busy;

endmodule

// File: rtl/sample_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned x signed multiplier between
// NUM_REQ requesters. Define SAMPLE_MUL_ARB_SAT_EN for saturating results.
module sample_mul_arbiter
  import sample_mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned A_WIDTH    = DEF_A_WIDTH,
  parameter int unsigned B_WIDTH    = DEF_B_WIDTH,
  parameter int unsigned P_WIDTH    = DEF_P_WIDTH,
  parameter int unsigned MUL_STAGES = DEF_MUL_STAGES,
  parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [P_WIDTH-1:0]           rsp_p,
  output logic                         busy
);

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [MAX_REQ-1:0]  valid_pad;
  logic [2:0]          ptr3;
  rr_pick_t            pick;
  logic                accept;
  logic [A_WIDTH-1:0]  sel_a;
  logic [B_WIDTH-1:0]  sel_b;
  logic [ID_WIDTH-1:0] sel_id;
  logic [ID_WIDTH-1:0] next_ptr;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    valid_pad              = '0;
    valid_pad[NUM_REQ-1:0] = req_valid;
    ptr3                   = 3'(rr_ptr);
    pick                   = rr_pick(valid_pad, ptr3, NUM_REQ);
    accept                 = pick.found && !ap_rst;
    sel_id                 = ID_WIDTH'(pick.idx);
    next_ptr               = (pick.idx == 3'(NUM_REQ - 1)) ? '0 : ID_WIDTH'(pick.idx + 3'd1);
  end

  // One-hot grant and operand mux for the winning requester.
  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick.idx == 3'(i)) begin
        req_ready[i] = accept;
        sel_a        = req_a[i*A_WIDTH +: A_WIDTH];
        sel_b        = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // Advance the pointer past the requester just served.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= next_ptr;
    end
  end

  sample_mul_arb_pipe #(
    .A_WIDTH    (A_WIDTH),
    .B_WIDTH    (B_WIDTH),
    .P_WIDTH    (P_WIDTH),
    .MUL_STAGES (MUL_STAGES),
    .ID_WIDTH   (ID_WIDTH)
  ) u_pipe (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (accept),
    .in_id     (sel_id),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

endmodule

// File: tb/tb_sample_mul_arbiter.sv
// Directed self-checking bench for sample_mul_arbiter (default geometry).
module tb_sample_mul_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [23:0] req_a;
  logic [43:0] req_b;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [10:0] rsp_p;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_rr [4];
  logic [10:0] exp_trunc;
  logic [10:0] exp_neg;

  always #5 ap_clk = ~ap_clk;

  sample_mul_arbiter #(
    .NUM_REQ    (4),
    .A_WIDTH    (6),
    .B_WIDTH    (11),
    .P_WIDTH    (11),
    .MUL_STAGES (2),
    .ID_WIDTH   (2)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [10:0] p);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'h1);
    chk({tag, "_id"},    32'(rsp_id),    32'(id));
    chk({tag, "_p"},     32'(rsp_p),     32'(p));
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_op(input int unsigned i, input logic [5:0] a, input logic [10:0] b);
    req_a[i*6 +: 6]   = a;
    req_b[i*11 +: 11] = b;
  endtask

  initial begin
    exp_rr[0] = 11'h6D4;  //  3 * -100 = -300
    exp_rr[1] = 11'h1F4;  // 10 *   50 =  500
    exp_rr[2] = 11'h418;  // 40 *  -25 = -1000
    exp_rr[3] = 11'h3FC;  // 17 *   60 =  1020
`ifdef SAMPLE_MUL_ARB_SAT_EN
    exp_trunc = 11'h3FF;
`else
    exp_trunc = 11'h3C1;
`endif
    exp_neg = 11'h400;

    // Reset with every requester asking: no grant during reset.
    ap_rst    = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    tick;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_p", 32'(rsp_p), 32'h0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    req_valid = 4'h0;
    ap_rst    = 1'b0;
    tick;

    // Single request: 5 * -3 = -15.
    set_op(0, 6'd5, 11'h7FD);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick;
    req_valid = 4'b0000;
    chk("single_busy", 32'(busy), 32'h1);
    tick;
    chk_rsp("single", 2'd0, 11'h7F1);
    tick;
    chk("single_done_valid", 32'(rsp_valid), 32'h0);
    chk("single_done_busy", 32'(busy), 32'h0);

    // Positive overflow: 63 * 1023 = 64449.
    set_op(1, 6'd63, 11'd1023);
    req_valid = 4'b0010;
    #1;
    chk("trunc_ready", 32'(req_ready), 32'h2);
    tick;
    req_valid = 4'b0000;
    tick;
    chk_rsp("trunc", 2'd1, exp_trunc);

    // Negative extreme: 63 * -1024 = -64512.
    set_op(2, 6'd63, 11'h400);
    req_valid = 4'b0100;
    #1;
    chk("neg_ready", 32'(req_ready), 32'h4);
    tick;
    req_valid = 4'b0000;
    tick;
    chk_rsp("neg", 2'd2, exp_neg);

    // Requester 3 wraps the pointer back to 0: 2 * 100 = 200.
    set_op(3, 6'd2, 11'd100);
    req_valid = 4'b1000;
    #1;
    chk("wrap_ready", 32'(req_ready), 32'h8);
    tick;
    req_valid = 4'b0000;
    tick;
    chk_rsp("wrap", 2'd3, 11'h0C8);
    tick;

    // Fairness: all requesters held valid for 8 cycles.
    set_op(0, 6'd3,  11'h79C);
    set_op(1, 6'd10, 11'd50);
    set_op(2, 6'd40, 11'h7E7);
    set_op(3, 6'd17, 11'd60);
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = 4'h0;
      #1;
      if (c < 8) chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) chk_rsp("rr", 2'((c - 2) % 4), exp_rr[(c - 2) % 4]);
      tick;
    end
    chk("rr_tail_valid", 32'(rsp_valid), 32'h0);
    chk("rr_tail_busy", 32'(busy), 32'h0);

    // Pointer skip: move pointer to 2, then only req0/req3 valid.
    req_valid = 4'b0010;
    #1;
    chk("skip_pre_ready", 32'(req_ready), 32'h2);
    tick;
    req_valid = 4'b1001;
    #1;
    chk("skip_ready3", 32'(req_ready), 32'h8);
    tick;
    chk("skip_ready0", 32'(req_ready), 32'h1);
    chk_rsp("skip_r1", 2'd1, exp_rr[1]);
    tick;
    req_valid = 4'b0000;
    #1;
    chk_rsp("skip_r3", 2'd3, exp_rr[3]);
    tick;
    chk_rsp("skip_r0", 2'd0, exp_rr[0]);
    chk("skip_rr_ptr", 32'(dut.rr_ptr), 32'h1);
    tick;
    tick;

    // Reset while an entry is in flight.
    req_valid = 4'b0010;
    #1;
    chk("mid_ready", 32'(req_ready), 32'h2);
    tick;
    req_valid = 4'b0000;
    ap_rst    = 1'b1;
    #1;
    chk("mid_busy_pre", 32'(busy), 32'h1);
    tick;
    ap_rst = 1'b0;
    chk("mid_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    chk("mid_busy_post", 32'(busy), 32'h0);
    for (int c = 0; c < 4; c++) begin
      chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
      tick;
    end
    req_valid = 4'hF;
    #1;
    chk("mid_regrant", 32'(req_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
